// File: rtl/sll_serial.sv
// Serial logical left shifter: moves the operand one bit per clock and
// presents in << shamt with zero fill behind a valid/ready handshake.
module sll_serial #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out,
  output logic                 busy
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_reg;
  logic [N-1:0]  acc_reg;
  logic [SW-1:0] count_reg;
  logic          out_valid_reg;
  logic          busy_reg;
  logic [N-1:0]  acc_shl;

  // One-position shift with zero fill; the top bit falls off.
  assign acc_shl[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_shl
      assign acc_shl[gi] = acc_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_reg       <= in;
            count_reg     <= shamt;
            busy_reg      <= 1'b1;
            out_valid_reg <= (shamt == '0);
            state_reg     <= (shamt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc_reg   <= acc_shl;
          count_reg <= count_reg - 1'b1;
          if (count_reg == SW'(1)) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // Held low while reset is asserted so no request is taken during reset.
  assign in_ready  = rst && (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign out       = acc_reg;

endmodule

// File: tb/tb_sll_serial.sv
// Bench for sll_serial: reset, directed vector table, hand-written corner
// sequences and a randomized run against a queue-based model of in << shamt.
module tb_sll_serial;
  localparam int N    = 32;
  localparam int NOPS = 1500;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [N-1:0] din = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [N-1:0] dout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] din;
    logic [4:0]  sh;
    int          hold;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          sh;
    int          acc_edge;
  } exp_t;

  vec_t vecs[7];
  exp_t q[$];

  sll_serial #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in(din),
    .shamt(shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(dout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a request, wait for it to be taken; returns at the negedge after the accept edge.
  task automatic send(input logic [31:0] d, input logic [4:0] s, input bit keep);
    int n = 0;
    in_valid = 1'b1;
    din      = d;
    shamt    = s;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 200), 32'd1);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  // Waits for the result, checks latency (edges after the accept edge), holds it, then completes it.
  task automatic collect(input string name, input logic [31:0] exp, input int lat, input int hold);
    int e = 0;
    out_ready = 1'b0;
    while (!out_valid && e < 40) begin
      check({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      e++;
    end
    check({name, "_latency"}, 32'(e), 32'(lat));
    check({name, "_out"}, dout, exp);
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
    repeat (hold) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_out"}, dout, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'hDEAD_BEEF, 5'd0,  0,  32'hDEAD_BEEF, 0};
    vecs[1] = '{32'h0000_0001, 5'd31, 0,  32'h8000_0000, 31};
    vecs[2] = '{32'hF000_000F, 5'd4,  10, 32'h0000_00F0, 4};
    vecs[3] = '{32'hFFFF_FFFF, 5'd1,  0,  32'hFFFF_FFFE, 1};
    vecs[4] = '{32'h1234_5678, 5'd16, 2,  32'h5678_0000, 16};
    vecs[5] = '{32'h8000_0001, 5'd31, 1,  32'h8000_0000, 31};
    vecs[6] = '{32'hA5A5_A5A5, 5'd8,  0,  32'hA5A5_A500, 8};

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", dout, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].din, vecs[i].sh, 1'b0);
      collect($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat, vecs[i].hold);
      $display("vec%0d: in=%h shamt=%0d -> out expected %h", i, vecs[i].din, vecs[i].sh, vecs[i].exp);
    end

    // Changed inputs and a pending request during SHIFT must not disturb the active op
    send(32'h0000_0003, 5'd10, 1'b1);
    din   = 32'h1234_5678;
    shamt = 5'd3;
    collect("ignored_first", 32'h0000_0C00, 10, 0);
    send(32'h1234_5678, 5'd3, 1'b0);
    collect("ignored_second", 32'h91A2_B3C0, 3, 0);
    $display("ignored-inputs sequence done");

    // Reset in the middle of a shift
    send(32'hFFFF_FFFF, 5'd20, 1'b0);
    repeat (4) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out", dout, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    repeat (25) begin
      @(negedge clk);
      check("midrst_no_spurious_valid", 32'(out_valid), 32'd0);
    end
    $display("mid-shift reset sequence done");

    // Randomized regression with handshake stalls
    begin
      int sent = 0;
      int done_cnt = 0;
      int lim = 0;
      bit acc_next = 1'b0;
      bit ov_seen = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      while (done_cnt < NOPS && lim < 60000) begin
        @(negedge clk);
        lim++;
        if (acc_next) begin
          in_valid = 1'b0;
          acc_next = 1'b0;
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            check("rand_spurious_valid", 32'(out_valid), 32'd0);
          end else if (!ov_seen) begin
            check("rand_out", dout, q[0].res);
            check("rand_latency", 32'(cyc - q[0].acc_edge), 32'(q[0].sh));
            ov_seen = 1'b1;
          end else begin
            check("rand_hold", dout, q[0].res);
          end
        end
        if (!in_valid && sent < NOPS && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          din      = $urandom;
          shamt    = 5'($urandom_range(0, 31));
          sent++;
        end
        if (in_valid && in_ready) begin
          q.push_back('{res: din << shamt, sh: int'(shamt), acc_edge: cyc + 1});
          acc_next = 1'b1;
        end
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          ov_seen = 1'b0;
          done_cnt++;
        end
      end
      check("rand_completed", 32'(done_cnt), 32'(NOPS));
      $display("random regression: %0d operations completed", done_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
